// File: rtl/ercm8_pkg.sv
// Shared widths for the ercm8 reconfigurable approximate multiplier.
package ercm8_pkg;
    localparam int OP_W   = 8;
    localparam int MASK_W = 7;
    localparam int PROD_W = 16;
endpackage : ercm8_pkg

// File: rtl/ercm8_col_cell.sv
// Full adder with an approximate bypass: when i_approx is set the three inputs
// are OR-reduced and no carry leaves the cell.
import ercm8_pkg::*;

module ercm8_col_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    input  logic i_approx,
    output logic o_sum,
    output logic o_carry
);
    logic w_xor;
    logic w_or;
    logic w_maj;

    assign w_xor   = i_a ^ i_b ^ i_c;
    assign w_or    = i_a | i_b | i_c;
    assign w_maj   = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
    assign o_sum   = i_approx ? w_or : w_xor;
    assign o_carry = i_approx ? 1'b0 : w_maj;
endmodule : ercm8_col_cell

// File: rtl/ercm8_v2_7.sv
// 8x8 unsigned multiplier whose low seven partial-product columns can each be
// switched to an OR approximation at run time; product is registered.
import ercm8_pkg::*;

module ercm8_v2_7 (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [OP_W-1:0]   i_dat_in_a,
    input  logic [OP_W-1:0]   i_dat_in_b,
    input  logic [MASK_W-1:0] i_mask,
    output logic [PROD_W-1:0] o_dat
);
    logic [MASK_W-1:0]      w_col_sum;
    logic [MASK_W-1:0][2:0] w_col_cy;
    logic [PROD_W-1:0]      w_low;
    logic [PROD_W-1:0]      w_high;
    logic [PROD_W-1:0]      w_prod;
    logic [PROD_W-1:0]      r_dat;

    // Each low column's own partial products run through a chain of cells:
    // one sum bit stays in column c, one carry per cell moves to column c+1.
    // Incoming carries are added later, so an approximated column only ORs its own bits.
    for (genvar c = 0; c < MASK_W; c++) begin : g_col
        logic [c:0] w_b;
        for (genvar i = 0; i <= c; i++) begin : g_pp
            assign w_b[i] = i_dat_in_a[i] & i_dat_in_b[c-i];
        end
        if (c == 0) begin : g_single
            assign w_col_sum[c] = w_b[0];
            assign w_col_cy[c]  = 3'b000;
        end else begin : g_chain
            localparam int NC = (c + 1) / 2;
            logic [NC-1:0] w_s;
            logic [NC-1:0] w_cy;
            for (genvar k = 0; k < NC; k++) begin : g_cell
                logic w_x;
                logic w_y;
                logic w_z;
                if (k == 0) begin : g_first
                    assign w_x = w_b[0];
                end else begin : g_next
                    assign w_x = w_s[k-1];
                end
                assign w_y = w_b[2*k+1];
                if (2*k+2 <= c) begin : g_three
                    assign w_z = w_b[2*k+2];
                end else begin : g_two
                    assign w_z = 1'b0;
                end
                ercm8_col_cell u_cell (
                    .i_a      (w_x),
                    .i_b      (w_y),
                    .i_c      (w_z),
                    .i_approx (i_mask[c]),
                    .o_sum    (w_s[k]),
                    .o_carry  (w_cy[k])
                );
            end
            assign w_col_sum[c] = w_s[NC-1];
            assign w_col_cy[c]  = 3'(w_cy);
        end
    end

    always_comb begin
        w_low = '0;
        for (int c = 0; c < MASK_W; c++) begin
            w_low = w_low + (PROD_W'(w_col_sum[c]) << c);
            for (int k = 0; k < 3; k++) begin
                w_low = w_low + (PROD_W'(w_col_cy[c][k]) << (c + 1));
            end
        end
    end

    // Columns 7..14 are always exact: keep only row bits at weight >= 2^7.
    always_comb begin
        w_high = '0;
        for (int i = 0; i < OP_W; i++) begin
            w_high = w_high +
                     ((PROD_W'(i_dat_in_b & {OP_W{i_dat_in_a[i]}}) << i) & PROD_W'(16'hFF80));
        end
    end

    assign w_prod = w_low + w_high;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_dat <= '0;
        end else begin
            r_dat <= w_prod;
        end
    end

    assign o_dat = r_dat;
endmodule : ercm8_v2_7

// File: tb/tb_ercm8_v2_7.sv
// Scoreboard bench for ercm8_v2_7: column-level golden model, one-cycle latency.
module tb_ercm8_v2_7;
    logic        clk;
    logic        rst_n;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [6:0]  mask;
    logic [15:0] dat_o;

    logic [15:0] exp_q[$];
    int          n_checks;
    int          n_errors;

    ercm8_v2_7 dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_dat_in_a (a),
        .i_dat_in_b (b),
        .i_mask     (mask),
        .o_dat      (dat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] golden(input logic [7:0] ga, input logic [7:0] gb,
                                           input logic [6:0] gm);
        int p;
        int cnt;
        p = 0;
        for (int c = 0; c < 15; c++) begin
            cnt = 0;
            for (int i = 0; i < 8; i++) begin
                if (c - i >= 0 && c - i < 8) cnt += int'(ga[i] & gb[c-i]);
            end
            if (c < 7 && gm[c]) p += (cnt != 0 ? 1 : 0) << c;
            else p += cnt << c;
        end
        return 16'(p);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic [7:0] sa, input logic [7:0] sb, input logic [6:0] sm,
                        input string tag, output logic [15:0] got);
        logic [15:0] e;
        @(negedge clk);
        a = sa;
        b = sb;
        mask = sm;
        exp_q.push_back(golden(sa, sb, sm));
        @(posedge clk);
        #1;
        got = dat_o;
        e = exp_q.pop_front();
        check_eq(tag, got, e);
    endtask

    task automatic hold_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        a = 8'd255;
        b = 8'd255;
        mask = 7'h00;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_eq("reset", dat_o, 0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] got;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [6:0]  rm;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        a = '0;
        b = '0;
        mask = '0;

        hold_reset(2);
        step(8'd255, 8'd255, 7'h00, "post_reset", got);
        check_eq("post_reset_const", got, 65025);

        step(8'd90, 8'd195, 7'h00, "exact_90x195", got);
        check_eq("exact_90x195_const", got, 17550);
        step(8'd255, 8'd255, 7'h00, "exact_max", got);
        check_eq("exact_max_const", got, 65025);
        step(8'd0, 8'd200, 7'h00, "exact_zero", got);
        check_eq("exact_zero_const", got, 0);
        step(8'd255, 8'd255, 7'h7F, "full_approx", got);
        check_eq("full_approx_const", got, 64383);
        step(8'd3, 8'd3, 7'h02, "col1_approx", got);
        check_eq("col1_approx_const", got, 7);
        step(8'd3, 8'd3, 7'h01, "col0_approx", got);
        check_eq("col0_approx_const", got, 9);
        step(8'd0, 8'd255, 7'h7F, "zero_a_approx", got);
        check_eq("zero_a_approx_const", got, 0);
        step(8'd255, 8'd0, 7'h55, "zero_b_approx", got);
        check_eq("zero_b_approx_const", got, 0);

        // Reset in the middle of a stream drops the in-flight product.
        @(negedge clk);
        a = 8'd200;
        b = 8'd177;
        mask = 7'h00;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_reset", dat_o, 0);
        rst_n = 1'b1;
        step(8'd17, 8'd13, 7'h00, "after_mid_reset", got);
        check_eq("after_mid_reset_const", got, 221);

        for (int n = 0; n < 10000; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rm = (n % 8 == 0) ? 7'h00 : 7'($urandom_range(0, 127));
            step(ra, rb, rm, "stream", got);
            check_eq("stream_le_ab", 32'(got <= 16'(ra * rb)), 1);
            if (rm == 7'h00) check_eq("stream_exact", got, 32'(ra) * 32'(rb));
        end

        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 256; j++) begin
                step(8'(i), 8'(j), 7'h00, "exhaustive", got);
                check_eq("exhaustive_ab", got, 32'(i * j));
            end
        end

        check_eq("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule : tb_ercm8_v2_7
